// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD constants for the BCD-to-binary encoder.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int BCD_DIGIT_W     = 4;
    localparam int BCD_MAX_DIGIT   = 9;
    localparam int BCD_CORR_THRESH = 8;
    localparam int BCD_CORR        = 3;
endpackage

// File: rtl/bcd_tens_units_encoder_if.sv
// bcd_tens_units_encoder_if: start/done conversion handshake between requester and encoder.
interface bcd_tens_units_encoder_if #(parameter int N_DIGITS = 2, parameter int BIN_W = 7);
    logic                  start;
    logic [4*N_DIGITS-1:0] bcd;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  error;
    modport master (output start, bcd, input bin, busy, done, error);
    modport slave  (input start, bcd, output bin, busy, done, error);
endinterface

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: one-digit correction step of reverse double dabble (>=8 -> -3).
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);
    assign o_d = (i_d >= BCD_DIGIT_W'(BCD_CORR_THRESH)) ? i_d - BCD_DIGIT_W'(BCD_CORR) : i_d;
endmodule

// File: rtl/bcd_tens_units_encoder.sv
// bcd_tens_units_encoder: sequential reverse double dabble BCD-to-binary, one bit per clock.
// Define BCD_ENC_DIGIT_CHECK_EN to reject operands holding a digit above 9 at load.
module bcd_tens_units_encoder
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int BIN_W    = 7
)(
    input logic                    clk,
    input logic                    reset,
    bcd_tens_units_encoder_if.slave bus
);
    localparam int DW = BCD_DIGIT_W * N_DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    state_t           r_state, w_nxt;
    logic [DW-1:0]    r_dig, w_dig_sh, w_dig_nx;
    logic [BIN_W-1:0] r_sh, w_sh_nx, r_bin;
    logic [CW-1:0]    r_cnt;
    logic             r_err, w_bad, w_last, w_load;

    assign w_load   = (r_state == IDLE) && bus.start;
    assign w_last   = r_cnt == CW'(BIN_W - 1);
    assign w_dig_sh = r_dig >> 1;
    assign w_sh_nx  = {r_dig[0], r_sh[BIN_W-1:1]};

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_corr
        bcd_digit_corr u_corr (
            .i_d(w_dig_sh[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_d(w_dig_nx[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_ENC_DIGIT_CHECK_EN
    logic [N_DIGITS-1:0] w_dig_bad;
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_chk
        assign w_dig_bad[i] = bus.bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    end
    assign w_bad = |w_dig_bad;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;

    always_comb begin
        w_nxt = r_state;
        if (w_load)                           w_nxt = w_bad ? DONE : SHIFT;
        else if (r_state == SHIFT && w_last)  w_nxt = DONE;
        else if (r_state == DONE)             w_nxt = IDLE;
    end

    // bin/error only change at the edge that enters DONE, so they hold through the next conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dig <= '0;
            r_sh  <= '0;
            r_cnt <= '0;
            r_bin <= '0;
            r_err <= 1'b0;
        end else if (w_load) begin
            r_dig <= bus.bcd;
            r_sh  <= '0;
            r_cnt <= '0;
            if (w_bad) begin
                r_bin <= '0;
                r_err <= 1'b1;
            end
        end else if (r_state == SHIFT) begin
            r_dig <= w_dig_nx;
            r_sh  <= w_sh_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_bin <= w_sh_nx;
                r_err <= 1'b0;
            end
        end
    end

    assign bus.bin   = r_bin;
    assign bus.error = r_err;
    assign bus.busy  = r_state == SHIFT;
    assign bus.done  = r_state == DONE;
endmodule

// File: tb/tb_bcd_tens_units_encoder.sv
// tb_bcd_tens_units_encoder: table-driven vectors with a result scoreboard plus corner sequences.
module tb_bcd_tens_units_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_tens_units_encoder_if #(.N_DIGITS(2), .BIN_W(7))  bus ();
    bcd_tens_units_encoder_if #(.N_DIGITS(3), .BIN_W(10)) bus3 ();

    bcd_tens_units_encoder #(.N_DIGITS(2), .BIN_W(7))  dut  (.clk(clk), .reset(reset), .bus(bus));
    bcd_tens_units_encoder #(.N_DIGITS(3), .BIN_W(10)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {logic [7:0] bcd; int bin; bit bad;} vec_t;
    typedef struct {int bin; bit err;} exp_t;

    vec_t tbl[$];
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk)
        if (!reset && bus.done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected_done: got done=1 expected no result pending at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_bin", int'(bus.bin), e.bin);
                check("sb_err", int'(bus.error), int'(e.err));
            end
        end

    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            nb += int'(bus.busy);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic convert(input logic [7:0] b, input int eb, input bit bad);
        int lat, nb;
        bus.bcd = b;
        bus.start = 1'b1;
        q.push_back('{bad ? 0 : eb, bad});
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, nb);
        check("latency", lat, bad ? 1 : 8);
        check("busy_cycles", nb, bad ? 0 : 7);
        @(negedge clk);
        check("done_pulse", int'(bus.done), 0);
        check("bin_hold", int'(bus.bin), bad ? 0 : eb);
        check("err_hold", int'(bus.error), int'(bad));
    endtask

    initial begin
        int lat, nb;
        logic [11:0] b3 [2];
        int e3 [2];
        bus.start = 1'b0;
        bus.bcd = '0;
        bus3.start = 1'b0;
        bus3.bcd = '0;
        tbl.push_back('{8'h42, 42, 1'b0});
        tbl.push_back('{8'h99, 99, 1'b0});
        tbl.push_back('{8'h00, 0, 1'b0});
`ifdef BCD_ENC_DIGIT_CHECK_EN
        tbl.push_back('{8'h3A, 0, 1'b1});
`endif
        tbl.push_back('{8'h17, 17, 1'b0});
        tbl.push_back('{8'h01, 1, 1'b0});
        tbl.push_back('{8'h10, 10, 1'b0});
        tbl.push_back('{8'h09, 9, 1'b0});
        tbl.push_back('{8'h90, 90, 1'b0});
        tbl.push_back('{8'h55, 55, 1'b0});
`ifdef BCD_ENC_DIGIT_CHECK_EN
        tbl.push_back('{8'hA0, 0, 1'b1});
        tbl.push_back('{8'hF9, 0, 1'b1});
`endif
        tbl.push_back('{8'h80, 80, 1'b0});

        #3;
        check("rst_bin", int'(bus.bin), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.error), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) convert(tbl[i].bcd, tbl[i].bin, tbl[i].bad);

        // start held through the whole conversion, operand changed mid-shift
        bus.bcd = 8'h25;
        bus.start = 1'b1;
        q.push_back('{25, 1'b0});
        @(posedge clk);
        repeat (3) @(negedge clk);
        bus.bcd = 8'h88;
        wait_done(lat, nb);
        check("held_latency", lat, 5);
        check("held_busy", nb, 4);
        q.push_back('{88, 1'b0});
        @(negedge clk);
        check("held_idle_done", int'(bus.done), 0);
        check("held_idle_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, nb);
        check("held_second_latency", lat, 8);
        check("held_second_busy", nb, 7);
        @(negedge clk);

        // asynchronous reset in the middle of a shift
        bus.bcd = 8'h63;
        bus.start = 1'b1;
        q.push_back('{63, 1'b0});
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check("arst_bin", int'(bus.bin), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_err", int'(bus.error), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        convert(8'h63, 63, 1'b0);

        // three-digit instance
        b3[0] = 12'h999; e3[0] = 999;
        b3[1] = 12'h512; e3[1] = 512;
        for (int j = 0; j < 2; j++) begin
            int l3;
            l3 = 0;
            bus3.bcd = b3[j];
            bus3.start = 1'b1;
            @(posedge clk);
            #1 bus3.start = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (bus3.done) begin
                    l3 = k;
                    break;
                end
            end
            check("d3_latency", l3, 11);
            check("d3_bin", int'(bus3.bin), e3[j]);
            check("d3_err", int'(bus3.error), 0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
